// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared sizes, FSM states and butterfly address helper for the FFT scheduler
package fft_pkg;

  localparam int N_LOG2 = 4;
  localparam int N      = 1 << N_LOG2;
  localparam int ADDR_W = N_LOG2;
  localparam int TW_W   = N_LOG2 - 1;
  localparam int STG_W  = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
  localparam int K_W    = N_LOG2 - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [TW_W-1:0]   tw;
  } bfly_t;

  // In-place DIT pairing: legs are 'half' apart, groups of 2*half, twiddle scaled up to N/2 steps.
  function automatic bfly_t bfly_addr(input logic [STG_W-1:0] stage, input logic [K_W-1:0] k);
    logic [ADDR_W-1:0] kk;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W-1:0] pos;
    logic [ADDR_W-1:0] grp;
    bfly_t             r;
    kk      = ADDR_W'(k);
    half    = ADDR_W'(1) << stage;
    pos     = kk & (half - 1'b1);
    grp     = kk >> stage;
    r.addr1 = (grp << (int'(stage) + 1)) + pos;
    r.addr2 = r.addr1 + half;
    r.tw    = TW_W'(pos << (N_LOG2 - 1 - int'(stage)));
    return r;
  endfunction

endpackage

// File: rtl/fft_mem_sched_if.sv
// rtl/fft_mem_sched_if.sv - control, read-issue and write-back signals of the FFT memory scheduler
interface fft_mem_sched_if;
  import fft_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic [STG_W-1:0]  stage;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [TW_W-1:0]   tw_idx;
  logic              wr_en_1;
  logic              wr_en_2;
  logic [ADDR_W-1:0] wr_addr_1;
  logic [ADDR_W-1:0] wr_addr_2;

  modport master (
    input  start,
    output busy, done, stage, rd_valid, rd_addr_1, rd_addr_2, tw_idx,
    output wr_en_1, wr_en_2, wr_addr_1, wr_addr_2
  );

  modport slave (
    output start,
    input  busy, done, stage, rd_valid, rd_addr_1, rd_addr_2, tw_idx,
    input  wr_en_1, wr_en_2, wr_addr_1, wr_addr_2
  );

endinterface

// File: rtl/fft_mem_sched_wb_delay.sv
// rtl/fft_mem_sched_wb_delay.sv - fixed-depth valid+address shift line replaying reads as write-backs
module fft_wb_delay #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr_1,
  input  logic [ADDR_W-1:0] in_addr_2,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr_1,
  output logic [ADDR_W-1:0] out_addr_2
);

  localparam int W = 1 + 2 * ADDR_W;

  logic [DEPTH-1:0][W-1:0] line_q;
  logic [DEPTH-1:0][W-1:0] line_d;

  always_comb begin
    line_d    = '0;
    line_d[0] = {in_valid, in_addr_1, in_addr_2};
    for (int i = 1; i < DEPTH; i++) begin
      line_d[i] = line_q[i-1];
    end
  end

  // Clearing every slot on reset is what drops in-flight write-backs of an aborted transform.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign {out_valid, out_addr_1, out_addr_2} = line_q[DEPTH-1];

endmodule

// File: rtl/fft_mem_sched.sv
// rtl/fft_mem_sched.sv - in-place radix-2 DIT butterfly address scheduler with write-back replay
module fft_mem_sched
  import fft_pkg::*;
#(
  parameter int BFLY_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fft_mem_sched_if.master bus
);

  localparam int CNT_W = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

  state_e            state_q, state_d;
  logic [STG_W-1:0]  stage_q, stage_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_addr_1_q, rd_addr_1_d;
  logic [ADDR_W-1:0] rd_addr_2_q, rd_addr_2_d;
  logic [TW_W-1:0]   tw_idx_q, tw_idx_d;
  bfly_t             bfly;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          stage_d = '0;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        if (k_q == K_W'(N / 2 - 1)) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      // The drain gap equals the write-back latency, so the next stage reads committed data.
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(BFLY_LAT - 1)) begin
          if (stage_q == STG_W'(N_LOG2 - 1)) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + 1'b1;
            k_d     = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are computed from the next state so that they come straight out of flops.
    bfly        = bfly_addr(stage_d, k_d);
    rd_valid_d  = (state_d == ST_RUN);
    rd_addr_1_d = rd_valid_d ? bfly.addr1 : '0;
    rd_addr_2_d = rd_valid_d ? bfly.addr2 : '0;
    tw_idx_d    = rd_valid_d ? bfly.tw : '0;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_addr_1_q <= '0;
      rd_addr_2_q <= '0;
      tw_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_1_q <= rd_addr_1_d;
      rd_addr_2_q <= rd_addr_2_d;
      tw_idx_q    <= tw_idx_d;
    end
  end

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr_1;
  logic [ADDR_W-1:0] wb_addr_2;

  fft_wb_delay #(
    .DEPTH (BFLY_LAT),
    .ADDR_W(ADDR_W)
  ) u_wb_delay (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_valid_q),
    .in_addr_1 (rd_addr_1_q),
    .in_addr_2 (rd_addr_2_q),
    .out_valid (wb_valid),
    .out_addr_1(wb_addr_1),
    .out_addr_2(wb_addr_2)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_addr_1 = rd_addr_1_q;
  assign bus.rd_addr_2 = rd_addr_2_q;
  assign bus.tw_idx    = tw_idx_q;
  assign bus.wr_en_1   = wb_valid;
  assign bus.wr_en_2   = wb_valid;
  assign bus.wr_addr_1 = wb_addr_1;
  assign bus.wr_addr_2 = wb_addr_2;

endmodule
